// File: rtl/sweep_response_classifier.sv
// sweep_response_classifier: scans the sweep table for the peak and -3 dB edges, then classifies the filter shape.
module sweep_response_classifier #(
  parameter int N_POINTS = 33,
  parameter int THR_NUM = 181,
  parameter int THR_SH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] amp_in,
  input  logic [11:0] phase_in,
  output logic [7:0]  raddr,
  output logic        busy,
  output logic        done,
  output logic [11:0] peak_amp,
  output logic [11:0] peak_phase,
  output logic [7:0]  peak_idx,
  output logic [7:0]  lo_idx,
  output logic [7:0]  hi_idx,
  output logic [2:0]  filter_type,
  output logic        flat_err
);
  typedef enum logic [2:0] {IDLE, SCAN_MAX, SCAN_THR, CLASSIFY, FIN} state_t;
  localparam logic [7:0] LAST = 8'(N_POINTS - 1);
  state_t state;
  logic [11:0] max_amp, max_ph;
  logic [7:0] max_idx, lo, hi;
  logic found, gap, dip;
  logic [19:0] amp_sc, thr;
  logic pass;
  assign amp_sc = 20'(amp_in) << THR_SH;
  assign thr = 20'(max_amp) * 20'(THR_NUM);
  assign pass = amp_sc >= thr;
  // gap marks a failing point after lo; a later pass turns it into an interior dip
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      raddr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      peak_amp <= '0;
      peak_phase <= '0;
      peak_idx <= '0;
      lo_idx <= '0;
      hi_idx <= '0;
      filter_type <= 3'd7;
      flat_err <= 1'b0;
      max_amp <= '0;
      max_ph <= '0;
      max_idx <= '0;
      lo <= '0;
      hi <= '0;
      found <= 1'b0;
      gap <= 1'b0;
      dip <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          raddr <= '0;
          if (start) begin
            busy <= 1'b1;
            state <= SCAN_MAX;
          end
        end
        SCAN_MAX: begin
          if (raddr == 8'd0 || amp_in > max_amp) begin
            max_amp <= amp_in;
            max_ph <= phase_in;
            max_idx <= raddr;
          end
          found <= 1'b0;
          gap <= 1'b0;
          dip <= 1'b0;
          raddr <= raddr == LAST ? 8'd0 : raddr + 8'd1;
          if (raddr == LAST) state <= SCAN_THR;
        end
        SCAN_THR: begin
          if (pass) begin
            if (!found) lo <= raddr;
            hi <= raddr;
            found <= 1'b1;
            if (gap) dip <= 1'b1;
          end else if (found) gap <= 1'b1;
          raddr <= raddr == LAST ? 8'd0 : raddr + 8'd1;
          if (raddr == LAST) state <= CLASSIFY;
        end
        CLASSIFY: begin
          peak_amp <= max_amp;
          peak_phase <= max_ph;
          peak_idx <= max_idx;
          lo_idx <= lo;
          hi_idx <= hi;
          flat_err <= max_amp == 12'd0;
          filter_type <= max_amp == 12'd0 ? 3'd7 :
                         lo == 8'd0 ? (hi == LAST ? (dip ? 3'd4 : 3'd0) : 3'd1) :
                         hi == LAST ? 3'd2 : 3'd3;
          busy <= 1'b0;
          done <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sweep_response_classifier.sv
// tb_sweep_response_classifier: directed tables with a done-driven scoreboard monitor.
module tb_sweep_response_classifier;
  logic clk = 0, rst = 1, start = 0;
  logic [11:0] amp_in, phase_in, peak_amp, peak_phase;
  logic [7:0] raddr, peak_idx, lo_idx, hi_idx;
  logic busy, done, flat_err;
  logic [2:0] filter_type;
  logic [11:0] amp_tab [0:32];
  logic [11:0] ph_tab [0:32];
  int cyc = 0, n_vec = 0, n_bad = 0;
  typedef struct {int amp; int ph; int idx; int lo; int hi; int ft; int err; int t0;} exp_t;
  exp_t q[$];

  sweep_response_classifier dut (
    .clk(clk), .rst(rst), .start(start), .amp_in(amp_in), .phase_in(phase_in),
    .raddr(raddr), .busy(busy), .done(done), .peak_amp(peak_amp), .peak_phase(peak_phase),
    .peak_idx(peak_idx), .lo_idx(lo_idx), .hi_idx(hi_idx), .filter_type(filter_type),
    .flat_err(flat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign amp_in = raddr < 8'd33 ? amp_tab[raddr] : 12'd0;
  assign phase_in = raddr < 8'd33 ? ph_tab[raddr] : 12'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc - e.t0, 68);
        chk("peak_amp", int'(peak_amp), e.amp);
        chk("peak_phase", int'(peak_phase), e.ph);
        chk("peak_idx", int'(peak_idx), e.idx);
        chk("lo_idx", int'(lo_idx), e.lo);
        chk("hi_idx", int'(hi_idx), e.hi);
        chk("filter_type", int'(filter_type), e.ft);
        chk("flat_err", int'(flat_err), e.err);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic fill(input int v);
    for (int i = 0; i < 33; i++) begin
      amp_tab[i] = 12'(v);
      ph_tab[i] = 12'(i * 7 + 3);
    end
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1;
    t0 = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_q;
    for (int i = 0; i < 120 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int a, input int p, input int i, input int l, input int h, input int f, input int e);
    int t0;
    pulse_start(t0);
    q.push_back('{a, p, i, l, h, f, e, t0});
    wait_q();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_peak_amp"}, int'(peak_amp), 0);
    chk({tag, "_peak_phase"}, int'(peak_phase), 0);
    chk({tag, "_peak_idx"}, int'(peak_idx), 0);
    chk({tag, "_lo_idx"}, int'(lo_idx), 0);
    chk({tag, "_hi_idx"}, int'(hi_idx), 0);
    chk({tag, "_filter_type"}, int'(filter_type), 7);
    chk({tag, "_flat_err"}, int'(flat_err), 0);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int t0;
    fill(0);
    repeat (2) @(negedge clk);
    rst = 0;
    chk_reset_state("reset");
    // lowpass
    fill(1000);
    for (int i = 0; i <= 14; i++) amp_tab[i] = 2000;
    run(2000, 3, 0, 0, 14, 1, 0);
    // bandpass
    fill(500);
    amp_tab[19] = 3000; amp_tab[20] = 4000; amp_tab[21] = 3000;
    run(4000, 143, 20, 19, 21, 3, 0);
    // highpass
    fill(100);
    for (int i = 16; i < 33; i++) amp_tab[i] = 3000;
    run(3000, 115, 16, 16, 32, 2, 0);
    // bandstop
    fill(1000);
    amp_tab[16] = 100;
    run(1000, 3, 0, 0, 32, 4, 0);
    // flat, first-tie peak
    fill(1000);
    run(1000, 3, 0, 0, 32, 0, 0);
    // all zero: everything passes a zero threshold
    fill(0);
    run(0, 3, 0, 0, 32, 7, 1);
    // exact threshold boundary: 181*256 == 256*181 passes, 180 fails
    fill(0);
    amp_tab[9] = 181; amp_tab[10] = 256; amp_tab[11] = 180;
    run(256, 73, 10, 9, 10, 3, 0);
    // start pulsed mid-scan is ignored
    fill(1000);
    for (int i = 0; i <= 14; i++) amp_tab[i] = 2000;
    pulse_start(t0);
    q.push_back('{2000, 3, 0, 0, 14, 1, 0, t0});
    while (cyc < t0 + 30) @(negedge clk);
    chk("busy_mid_scan", int'(busy), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_q();
    repeat (80) @(negedge clk);
    // reset mid-scan aborts without done
    fill(500);
    amp_tab[20] = 4000;
    pulse_start(t0);
    while (cyc < t0 + 40) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_state("abort");
    repeat (80) @(negedge clk);
    // normal run after abort
    fill(500);
    amp_tab[19] = 3000; amp_tab[20] = 4000; amp_tab[21] = 3000;
    run(4000, 143, 20, 19, 21, 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
